// File: rtl/turn_lamp_monitor.sv
// Lamp-bus checker for the turn-signal sequencer: recovers direction/phase,
// counts completed sweeps and latches the first fault cause.
module turn_lamp_monitor #(
    parameter int unsigned MAX_HOLD = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Lamps,
    output logic [1:0] Dir,
    output logic [1:0] Phase,
    output logic [7:0] SweepCnt,
    output logic       Fault,
    output logic [1:0] FaultCode
);

    localparam int unsigned HOLD_W = 4;

    // Sweep states carry their phase in bits [1:0]; bit 2 marks the right group.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] L1   = 3'd1;
    localparam logic [2:0] L2   = 3'd2;
    localparam logic [2:0] L3   = 3'd3;
    localparam logic [2:0] FLT  = 3'd4;
    localparam logic [2:0] R1   = 3'd5;
    localparam logic [2:0] R2   = 3'd6;
    localparam logic [2:0] R3   = 3'd7;

    localparam logic [1:0] CODE_PATTERN    = 2'b01;
    localparam logic [1:0] CODE_TRANSITION = 2'b10;
    localparam logic [1:0] CODE_STUCK      = 2'b11;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nx;
    logic [HOLD_W:0]   hold_inc;
    logic [7:0]        cnt_nx;
    logic [1:0]        code_nx;
    logic [2:0]        lamp_state;
    logic              lamp_legal;
    logic [1:0]        dir_nx;
    logic [1:0]        phase_nx;

    // Map the lamp bus onto the state it represents.
    always_comb begin
        lamp_state = IDLE;
        lamp_legal = 1'b1;
        case (Lamps)
            6'b000000: lamp_state = IDLE;
            6'b001000: lamp_state = L1;
            6'b011000: lamp_state = L2;
            6'b111000: lamp_state = L3;
            6'b000100: lamp_state = R1;
            6'b000110: lamp_state = R2;
            6'b000111: lamp_state = R3;
            default:   lamp_legal = 1'b0;
        endcase
    end

    assign hold_inc = {1'b0, hold} + (HOLD_W+1)'(1);

    // Next-state, hold counter, sweep counter and fault cause.
    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        cnt_nx   = SweepCnt;
        code_nx  = FaultCode;
        if (state != FLT) begin
            if (!lamp_legal) begin
                state_nx = FLT;
                code_nx  = CODE_PATTERN;
            end else if (state == IDLE) begin
                if (lamp_state == L1 || lamp_state == R1) begin
                    state_nx = lamp_state;
                end else if (lamp_state != IDLE) begin
                    state_nx = FLT;
                    code_nx  = CODE_TRANSITION;
                end
            end else if (lamp_state == IDLE) begin
                state_nx = IDLE;
                if (state[1:0] == 2'd3) begin
                    cnt_nx = SweepCnt + 8'd1;
                end
            end else if (lamp_state == state) begin
                if (hold_inc > (HOLD_W+1)'(MAX_HOLD)) begin
                    state_nx = FLT;
                    code_nx  = CODE_STUCK;
                end else begin
                    hold_nx = hold_inc[HOLD_W-1:0];
                end
            end else if (state[1:0] != 2'd3 && lamp_state == state + 3'd1) begin
                state_nx = lamp_state;
            end else begin
                state_nx = FLT;
                code_nx  = CODE_TRANSITION;
            end
            if (state_nx != state) begin
                hold_nx = '0;
            end
        end
    end

    // Output decode of the upcoming state so outputs come straight from flops.
    always_comb begin
        dir_nx   = 2'b00;
        phase_nx = 2'd0;
        if (state_nx != IDLE && state_nx != FLT) begin
            dir_nx   = state_nx[2] ? 2'b01 : 2'b10;
            phase_nx = state_nx[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            hold      <= '0;
            Dir       <= 2'b00;
            Phase     <= 2'd0;
            SweepCnt  <= 8'd0;
            Fault     <= 1'b0;
            FaultCode <= 2'b00;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            Dir       <= dir_nx;
            Phase     <= phase_nx;
            SweepCnt  <= cnt_nx;
            Fault     <= (state_nx == FLT);
            FaultCode <= code_nx;
        end
    end

endmodule

// File: tb/tb_turn_lamp_monitor.sv
// Bench for turn_lamp_monitor: directed scenarios plus random lamp traffic,
// every edge compared against a direction/phase reference model.
module tb_turn_lamp_monitor;

    localparam int MH = 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] Lamps = 6'd0;
    logic [1:0] Dir;
    logic [1:0] Phase;
    logic [7:0] SweepCnt;
    logic       Fault;
    logic [1:0] FaultCode;

    int total = 0;
    int bad   = 0;

    // Reference model: direction (0 idle, 1 right, 2 left), lit count, etc.
    int m_dir = 0, m_ph = 0, m_hold = 0, m_cnt = 0, m_fault = 0, m_code = 0;

    turn_lamp_monitor #(.MAX_HOLD(MH)) dut (
        .CLK(CLK), .RST(RST), .Lamps(Lamps), .Dir(Dir), .Phase(Phase),
        .SweepCnt(SweepCnt), .Fault(Fault), .FaultCode(FaultCode)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Lamp word for direction d with n lamps lit, lit from the inner lamp outward.
    function automatic logic [5:0] pat(input int d, input int n);
        logic [5:0] ones;
        ones = 6'((1 << n) - 1);
        if (d == 2) return ones << 3;
        if (d == 1) return ones << (3 - n);
        return 6'd0;
    endfunction

    task automatic model_edge(input logic [5:0] l, input logic r);
        int d, n, legal, fc;
        if (r) begin
            m_dir = 0; m_ph = 0; m_hold = 0; m_cnt = 0; m_fault = 0; m_code = 0;
            return;
        end
        if (m_fault != 0) return;
        legal = (l == 6'd0); d = 0; n = 0;
        for (int k = 1; k <= 3; k++) begin
            if (l == pat(2, k)) begin legal = 1; d = 2; n = k; end
            if (l == pat(1, k)) begin legal = 1; d = 1; n = k; end
        end
        fc = 0;
        if (legal == 0) fc = 1;
        else if (m_dir == 0) begin
            if (d != 0) begin
                if (n == 1) begin m_dir = d; m_ph = 1; m_hold = 0; end
                else fc = 2;
            end
        end else if (d == 0) begin
            if (m_ph == 3) m_cnt = (m_cnt + 1) % 256;
            m_dir = 0; m_ph = 0; m_hold = 0;
        end else if (d == m_dir && n == m_ph) begin
            if (m_hold + 1 > MH) fc = 3;
            else m_hold++;
        end else if (d == m_dir && n == m_ph + 1) begin
            m_ph++; m_hold = 0;
        end else fc = 2;
        if (fc != 0) begin
            m_fault = 1; m_code = fc; m_dir = 0; m_ph = 0;
        end
    endtask

    task automatic step(input logic [5:0] l, input logic r);
        @(negedge CLK);
        Lamps = l;
        RST   = r;
        @(posedge CLK);
        model_edge(l, r);
        #1;
        check("dir", int'(Dir), m_dir);
        check("phase", int'(Phase), m_ph);
        check("sweepcnt", int'(SweepCnt), m_cnt);
        check("fault", int'(Fault), m_fault);
        check("faultcode", int'(FaultCode), m_code);
    endtask

    task automatic sweep(input int d);
        for (int k = 1; k <= 3; k++) step(pat(d, k), 1'b0);
        step(6'd0, 1'b0);
    endtask

    initial begin
        int r, cur;
        logic [5:0] l;

        step(6'd0, 1'b1);
        check("reset_cnt", int'(SweepCnt), 0);

        // Left loop
        step(6'b001000, 1'b0); check("l1_dir", int'(Dir), 2); check("l1_ph", int'(Phase), 1);
        step(6'b011000, 1'b0); check("l2_ph", int'(Phase), 2);
        step(6'b111000, 1'b0); check("l3_ph", int'(Phase), 3);
        step(6'b000000, 1'b0); check("left_cnt", int'(SweepCnt), 1);

        // Right loops then reset mid-sweep
        for (int s = 0; s < 4; s++) begin
            step(6'b000100, 1'b0); check("r_dir", int'(Dir), 1);
            step(6'b000110, 1'b0); step(6'b000111, 1'b0); step(6'b000000, 1'b0);
        end
        check("right_cnt", int'(SweepCnt), 5);
        step(6'b000111, 1'b0);
        check("r3_direct_fault", int'(FaultCode), 2);
        step(6'b000111, 1'b1);
        check("rst_cnt", int'(SweepCnt), 0);
        check("rst_fault", int'(Fault), 0);

        // Abort then direction change, then a direct jump
        step(6'b000100, 1'b0); step(6'b000110, 1'b0); step(6'b000000, 1'b0);
        check("abort_cnt", int'(SweepCnt), 0);
        step(6'b001000, 1'b0); step(6'b011000, 1'b0);
        check("chg_dir", int'(Dir), 2);
        step(6'b000100, 1'b0);
        check("jump_fault", int'(Fault), 1);
        check("jump_code", int'(FaultCode), 2);

        // Illegal pattern, then frozen while sweeps continue
        step(6'd0, 1'b1);
        step(6'b100001, 1'b0);
        check("illegal_code", int'(FaultCode), 1);
        sweep(2); sweep(1);
        check("frozen_cnt", int'(SweepCnt), 0);
        check("frozen_code", int'(FaultCode), 1);

        // Stuck lamp
        step(6'd0, 1'b1);
        step(6'b001000, 1'b0);
        step(6'b011000, 1'b0);
        step(6'b011000, 1'b0); check("hold1_ok", int'(Fault), 0);
        step(6'b011000, 1'b0); check("hold2_code", int'(FaultCode), 3);

        // Counter wrap
        step(6'd0, 1'b1);
        for (int s = 0; s < 255; s++) sweep((s % 2) + 1);
        check("cnt_255", int'(SweepCnt), 255);
        sweep(2);
        check("cnt_wrap", int'(SweepCnt), 0);
        check("wrap_nofault", int'(Fault), 0);

        // Random traffic biased towards legal sweeps
        step(6'd0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            cur = pat(m_dir, m_ph);
            if (r < 2 || (m_fault != 0 && r < 25)) begin
                step(6'($urandom), 1'b1);
            end else if (r < 7) begin
                step(6'($urandom), 1'b0);
            end else if (r < 20) begin
                step(6'(cur), 1'b0);
            end else if (r < 25) begin
                step(pat(int'($urandom_range(0, 2)), int'($urandom_range(1, 3))), 1'b0);
            end else begin
                if (m_dir == 0)
                    l = (r < 40) ? 6'd0 : pat((r % 2) + 1, 1);
                else if (m_ph == 3 || r > 93)
                    l = 6'd0;
                else
                    l = pat(m_dir, m_ph + 1);
                step(l, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
